// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver.
// Two-flop input synchronizer, oversampling bit FSM with a down-counter,
// a small circular receive FIFO, and three word registers
// (RXDATA / STATUS / CTRL) with a level interrupt while data is pending.
module uart_rx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h2000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        rx_valid,
    output logic        rx_interrupt
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

    localparam logic [31:0] A_DATA = BASE_ADDR;
    localparam logic [31:0] A_STAT = BASE_ADDR + 32'h4;
    localparam logic [31:0] A_CTRL = BASE_ADDR + 32'h8;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // receiver state
    logic          rx_meta_q, rx_s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shreg_q, shreg_d;

    // FIFO and register state
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d, irq_en_q, irq_en_d, irq_q;

    // strobes
    logic push_req, ferr_set, push, pop, ovr_set, full, empty;
    logic hit_data, hit_stat, hit_ctrl;
    logic [4:0] cnt5;
    logic wd_unused;

    assign wd_unused = ^{write_data[31:4], write_data[1]};

    // two-flop synchronizer; idles high so reset cannot fake a start bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM state register together with its bit counter and shift register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
        end
    end

    // next-state: each phase counts down and acts on the cycle cnt is 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HALF_M1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx_s_q) begin
                    cnt_d   = FULL_M1;
                    bidx_d  = 3'd0;
                    state_d = S_DATA;
                end else begin
                    // line back high at mid-bit: glitch, not a start bit
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    cnt_d   = FULL_M1;
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: completed frame either delivers a byte or a framing error
    always_comb begin
        push_req = 1'b0;
        ferr_set = 1'b0;
        if (state_q == S_STOP && cnt_q == '0) begin
            push_req = rx_s_q;
            ferr_set = !rx_s_q;
        end
    end

    // bus decode, FIFO control and register next-state
    always_comb begin
        hit_data = (addr == A_DATA);
        hit_stat = (addr == A_STAT);
        hit_ctrl = (addr == A_CTRL);
        rx_valid = read_enable & (hit_data | hit_stat | hit_ctrl);

        empty   = (count_q == '0);
        full    = (count_q == DEPTH_N);
        pop     = read_enable & hit_data & !empty;
        // a full FIFO still takes the byte when a pop frees a slot this cycle
        push    = push_req & (!full | pop);
        ovr_set = push_req & full & !pop;

        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + NW'(1);
        else if (pop && !push) count_d = count_q - NW'(1);

        // write-one-to-clear first so a same-cycle set event overrides it
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (write_enable && hit_stat && write_data[2]) ovr_d  = 1'b0;
        if (write_enable && hit_stat && write_data[3]) ferr_d = 1'b0;
        if (ovr_set)  ovr_d  = 1'b1;
        if (ferr_set) ferr_d = 1'b1;

        irq_en_d = irq_en_q;
        if (write_enable && hit_ctrl) irq_en_d = write_data[0];
    end

    // combinational read mux; STATUS reflects the pre-update register values
    always_comb begin
        cnt5      = 5'(count_q);
        read_data = '0;
        if (read_enable) begin
            if (hit_data && !empty)
                read_data = {24'b0, mem_q[rptr_q]};
            else if (hit_stat)
                read_data = {23'b0, cnt5, ferr_q, ovr_q, full, !empty};
            else if (hit_ctrl)
                read_data = {31'b0, irq_en_q};
        end
    end

    // FIFO pointers, flags, control and the registered interrupt
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & (count_q != '0);
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= shreg_q;
    end

    assign rx_interrupt = irq_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven register checks, hand sequences for the timing
// corners, and a randomized phase compared against a queue-based model.
module tb_uart_rx;

    localparam int          CPB    = 16;
    localparam int          DEP    = 4;
    localparam logic [31:0] BASE   = 32'h2000_0100;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;
    localparam logic [31:0] A_BAD  = BASE + 32'hC;
    localparam int          FRAME  = 10 * CPB;

    localparam int OP_RD = 0, OP_WR = 1, OP_SEND = 2, OP_SENDBAD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        rx_valid;
    logic        rx_interrupt;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .rx(rx), .addr(addr), .write_data(write_data),
        .write_enable(write_enable), .read_enable(read_enable),
        .read_data(read_data), .rx_valid(rx_valid), .rx_interrupt(rx_interrupt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model: a byte queue plus the three flags
    logic [7:0] mq[$];
    logic m_ovr = 1'b0, m_ferr = 1'b0, m_irq_en = 1'b0;

    function automatic logic [31:0] m_status();
        return {23'b0, 5'(mq.size()), m_ferr, m_ovr, (mq.size() == DEP), (mq.size() != 0)};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == A_DATA) return (mq.size() != 0) ? {24'b0, mq[0]} : 32'h0;
        if (a == A_STAT) return m_status();
        if (a == A_CTRL) return {31'b0, m_irq_en};
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; write_data = d; write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0; addr = '0; write_data = '0;
        if (a == A_STAT) begin
            if (d[2]) m_ovr  = 1'b0;
            if (d[3]) m_ferr = 1'b0;
        end
        if (a == A_CTRL) m_irq_en = d[0];
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        addr = a; read_enable = 1'b1;
        #1;
        d = read_data;
        v = rx_valid;
        @(negedge clk);
        read_enable = 1'b0; addr = '0;
        if (a == A_DATA && mq.size() != 0) void'(mq.pop_front());
    endtask

    // drive one 8N1 frame (start, 8 data LSB first, stop) plus idle gap;
    // optionally pulse reset at frame cycle rst_at; report first irq cycle
    task automatic send(input logic [7:0] b, input logic stopb, input int rst_at,
                        output int irq_first);
        irq_first = -1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i < CPB)            rx = 1'b0;
            else if (i < 9 * CPB)   rx = b[(i - CPB) / CPB];
            else                    rx = stopb;
            rst = !(rst_at >= 0 && i >= rst_at && i < rst_at + 2);
            if (irq_first < 0 && rx_interrupt) irq_first = i;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = 1'b1;
            rst = 1'b1;
        end
        if (rst_at >= 0) begin
            mq.delete();
            m_ovr = 1'b0; m_ferr = 1'b0; m_irq_en = 1'b0;
        end else if (stopb) begin
            if (mq.size() < DEP) mq.push_back(b);
            else                 m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        ev;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int op, input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp, input logic ev);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.exp = exp; v.ev = ev;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic        rv;
        int          irqf;
        int          op;
        logic [7:0]  rb;

        // reset, then register behaviour from the table
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("reset_irq", {31'b0, rx_interrupt}, 32'h0);

        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h00, 1));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h00, 1));
        tbl.push_back(mk(OP_RD, A_CTRL, 0, 32'h00, 1));
        tbl.push_back(mk(OP_SEND, 0, 32'hA5, 0, 0));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h11, 1));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'hA5, 1));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h00, 1));
        for (int k = 1; k <= 5; k++) tbl.push_back(mk(OP_SEND, 0, k, 0, 0));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h47, 1));
        for (int k = 1; k <= 4; k++) tbl.push_back(mk(OP_RD, A_DATA, 0, k, 1));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h04, 1));
        tbl.push_back(mk(OP_WR, A_STAT, 32'h4, 0, 0));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h00, 1));
        tbl.push_back(mk(OP_SEND, 0, 32'h06, 0, 0));
        tbl.push_back(mk(OP_SEND, 0, 32'h07, 0, 0));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h06, 1));
        tbl.push_back(mk(OP_SEND, 0, 32'h08, 0, 0));
        tbl.push_back(mk(OP_SEND, 0, 32'h09, 0, 0));
        tbl.push_back(mk(OP_SEND, 0, 32'h0A, 0, 0));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h43, 1));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h07, 1));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h08, 1));
        tbl.push_back(mk(OP_SEND, 0, 32'h0B, 0, 0));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h09, 1));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h0A, 1));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h0B, 1));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h00, 1));
        tbl.push_back(mk(OP_RD, A_DATA, 0, 32'h00, 1));
        tbl.push_back(mk(OP_RD, A_BAD,  0, 32'h00, 0));
        tbl.push_back(mk(OP_WR, A_DATA, 32'hFF, 0, 0));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h00, 1));
        tbl.push_back(mk(OP_SENDBAD, 0, 32'h55, 0, 0));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h08, 1));
        tbl.push_back(mk(OP_WR, A_STAT, 32'h8, 0, 0));
        tbl.push_back(mk(OP_RD, A_STAT, 0, 32'h00, 1));

        foreach (tbl[k]) begin
            case (tbl[k].op)
                OP_RD: begin
                    bus_read(tbl[k].a, rd, rv);
                    chk($sformatf("tbl%0d_data", k), rd, tbl[k].exp);
                    chk($sformatf("tbl%0d_valid", k), {31'b0, rv}, {31'b0, tbl[k].ev});
                end
                OP_WR:   bus_write(tbl[k].a, tbl[k].d);
                default: send(tbl[k].d[7:0], tbl[k].op == OP_SEND, -1, irqf);
            endcase
        end

        // interrupt latency and fall after the popping read
        bus_write(A_CTRL, 32'h1);
        send(8'h3C, 1'b1, -1, irqf);
        chk("irq_latency", {31'b0, (irqf >= 155 && irqf <= 158)}, 32'h1);
        chk("irq_level", {31'b0, rx_interrupt}, 32'h1);
        bus_read(A_DATA, rd, rv);
        chk("irq_data", rd, 32'h3C);
        @(negedge clk);
        chk("irq_fall", {31'b0, rx_interrupt}, 32'h0);

        // 4-clock low glitch is not a start bit
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(A_STAT, rd, rv);
        chk("glitch_status", rd, 32'h0);

        // reset during data bit 3 of 0xFF, then a clean 0x81
        send(8'hFF, 1'b1, 4 * CPB + 6, irqf);
        bus_read(A_STAT, rd, rv);
        chk("midrst_status", rd, 32'h0);
        bus_read(A_CTRL, rd, rv);
        chk("midrst_ctrl", rd, 32'h0);
        send(8'h81, 1'b1, -1, irqf);
        bus_read(A_STAT, rd, rv);
        chk("post_rst_status", rd, 32'h11);
        bus_read(A_DATA, rd, rv);
        chk("post_rst_data", rd, 32'h81);

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 10);
            if (op <= 3) begin
                rb = 8'($urandom_range(0, 255));
                send(rb, $urandom_range(0, 7) != 0, -1, irqf);
                chk($sformatf("rnd%0d_irq", n), {31'b0, rx_interrupt},
                    {31'b0, m_irq_en && mq.size() != 0});
            end else if (op <= 7 || op == 10) begin
                logic [31:0] a;
                logic [31:0] e;
                a = (op <= 6) ? A_DATA : (op == 7) ? A_STAT : A_BAD;
                e = m_read(a);
                bus_read(a, rd, rv);
                chk($sformatf("rnd%0d_read", n), rd, e);
                chk($sformatf("rnd%0d_valid", n), {31'b0, rv}, {31'b0, a != A_BAD});
            end else if (op == 8) begin
                bus_write(A_STAT, {28'b0, 2'($urandom_range(0, 3)), 2'b0});
                bus_read(A_STAT, rd, rv);
                chk($sformatf("rnd%0d_w1c", n), rd, m_status());
            end else begin
                bus_write(A_CTRL, {31'b0, 1'($urandom_range(0, 1))});
                bus_read(A_CTRL, rd, rv);
                chk($sformatf("rnd%0d_ctrl", n), rd, {31'b0, m_irq_en});
            end
        end
        while (mq.size() != 0) begin
            logic [31:0] e;
            e = m_read(A_DATA);
            bus_read(A_DATA, rd, rv);
            chk("drain_data", rd, e);
        end
        bus_read(A_STAT, rd, rv);
        chk("final_status", rd, m_status());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped 8N1 UART receiver, the receive-side counterpart of the existing `uart` transmitter. It sits on the CPU data bus beside `uart` and `timer`, decoded from `data_mem_addr`, with the same bus signal style. It oversamples the asynchronous `rx` pin with a per-bit counter and buffers received bytes in a small FIFO. It exposes the bytes, status and error flags through three word registers and raises a level interrupt while data is pending.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per bit period (100 MHz / 115200); must be >= 4.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, 2..16.
- `BASE_ADDR`, 32'h2000_0100: byte address of register 0; registers are at +0x0, +0x4 and +0x8.

Ports:
- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `rx`  in  1  asynchronous serial input; idles high.
- `addr`  in  32  CPU data address.
- `write_data`  in  32  CPU store data.
- `write_enable`  in  1  store strobe, already qualified by the top-level UART-RX decode.
- `read_enable`  in  1  load strobe, already qualified; asserted for exactly one cycle per load.
- `read_data`  out  32  combinational register read data; 0 when not reading a valid offset.
- `rx_valid`  out  1  combinational; high when `read_enable` is high and `addr` hits one of the 3 offsets.
- `rx_interrupt`  out  1  registered level interrupt.

## Operation
- Input sync: 2-flop synchronizer on `rx`. Both flops reset to 1. The FSM sees only the second flop (`rx_s`).
- FSM states:
  - IDLE: while `rx_s`=1, stay. On `rx_s`=0, load the counter and go to START.
  - START: wait `CLKS_PER_BIT/2` cycles (mid-bit). If `rx_s`=0, go to DATA with bit index 0. If `rx_s`=1, treat as a glitch and return to IDLE; no flags change.
  - DATA: wait `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register (LSB first), increment the index. After bit 7, go to STOP.
  - STOP: wait `CLKS_PER_BIT` cycles and sample. Then go to IDLE.
    - Sample = 1: push the byte to the FIFO. If the FIFO is full with no pop that cycle, drop the byte and set `ovr`.
    - Sample = 0: discard the byte and set `ferr`.
- Counter: `$clog2(CLKS_PER_BIT)` bits, counts down to 0. Action occurs on the cycle the counter reaches 0.
- FIFO: circular buffer with read/write pointers and a `$clog2(FIFO_DEPTH)+1`-bit `count`.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push and pop in the same cycle keeps `count` unchanged; when full, that push is accepted.
  - A pop on empty is ignored.
- Registers (offsets from `BASE_ADDR`):
  - +0x0 RXDATA, read-only:
    - Not empty: `{24'b0, head}`, and a read pops the head.
    - Empty: reads 0 with no pop.
    - Writes are ignored.
  - +0x4 STATUS:
    - [0] not-empty.
    - [1] full.
    - [2] `ovr`, sticky.
    - [3] `ferr`, sticky.
    - [8:4] `count` (zero-extended).
    - Other bits are 0.
    - Write 1 to bit 2 or bit 3 to clear that flag. If a set event occurs the same cycle as the clear, set wins.
  - +0x8 CTRL: bit 0 = `irq_en`, read/write. Other bits read 0.
- Any other address within the block's window: `rx_valid`=0, `read_data`=0, writes ignored.
- `rx_interrupt` <= `irq_en & (count != 0)`.

## Timing
- Reset (`rst`=0 at a clock edge) takes effect at that edge, including mid-frame:
  - FSM to IDLE, counter 0, synchronizer to 1.
  - FIFO emptied (pointers and `count` 0).
  - `ovr`, `ferr`, `irq_en` and `rx_interrupt` cleared to 0.
  - `read_data`/`rx_valid` follow combinationally (0 with no read).
  - Any partially received byte is lost.
- Start-bit falling edge on the pin to FSM leaving IDLE: 3 clocks (2 sync + 1).
- Push occurs on the STOP sample edge. The byte is visible in STATUS/RXDATA from the next cycle; `rx_interrupt` rises one cycle after that.
- Pin start edge to FIFO push: 2 + 1 + `CLKS_PER_BIT/2` + 9*`CLKS_PER_BIT` cycles, ±1.
- A new start bit is accepted immediately after STOP; there is no extra idle requirement.
- Read data is combinational on `addr`/`read_enable` in the same cycle. The pop, W1C clears and CTRL writes take effect at the end of that cycle.
- A read of STATUS in the push cycle returns the pre-push value.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- Reset: drive `rst`=0 for 2 cycles, then read STATUS -> 0x0000_0000; `rx_interrupt`=0; RXDATA reads 0.
- Single byte: send 0xA5 8N1 with a 1-bit stop, then read STATUS -> 0x0000_0011. Read RXDATA -> 0x0000_00A5. Read STATUS again -> 0x0000_0000.
- Interrupt: write CTRL=1, send 0x3C -> `rx_interrupt`=1 within 2 cycles of the push; read RXDATA -> 0x3C; `rx_interrupt` falls the next cycle.
- Overflow/wrap: send 0x01..0x05 with no reads -> STATUS = 0x0000_0047 (count 4, full, ovr). RXDATA reads return 0x01, 0x02, 0x03, 0x04. Write STATUS=0x4 -> `ovr`=0. Then send 6 more bytes with reads interleaved to confirm pointer wrap and in-order data.
- Framing/glitch: send 0x55 with stop=0 -> `ferr`=1 and count 0. Pulse `rx` low for 4 clocks -> no byte received and no flag set.
- Mid-frame reset: assert `rst`=0 during DATA bit 3 of 0xFF -> FIFO empty. The next clean 0x81 is received correctly.
